mergesort_slave_loader: RTL and testbench
=========================================

// Module: mergesort_slave_loader
// PURPOSE
//  Upstream driver for the HLS-generated mergesort `main` core. Streams BASE_ADDR-relative input bytes into
//  main's slave RAM port, pulses start_port, times the run until done_port, then reads the array back.
//  Readback bytes are streamed out while a sortedness check (signed, little-endian elements) runs on them.
//  Replaces the tied-off S_* slave signals with a synthesizable preload/readback harness.
// PARAMETERS
//  N_CH       2         slave channels of main (only channel 0 is driven; others are held 0)
//  ADDR_W     7         address bits per channel
//  DATA_W     8         data bits per channel (one byte per access)
//  SIZE_W     4         data_ram_size bits per channel; driven to DATA_W on access
//  N_BYTES    32        array size in bytes (N_BYTES/ELEM_BYTES elements)
//  ELEM_BYTES 4         bytes per int element
//  BASE_ADDR  0         byte address of array[0] in main's slave space
//  TIMEOUT    200000000 max RUN cycles before abort
// PORTS
//  clock            in   1               rising-edge clock
//  reset            in   1               async, active-low
//  go               in   1               1-cycle request to start a load/run/readback pass (ignored unless IDLE)
//  in_valid         in   1               input byte valid
//  in_data          in   8               input byte, array order, byte 0 first
//  in_ready         out  1               loader accepts in_data this cycle
//  out_valid        out  1               readback byte valid
//  out_data         out  8               readback byte
//  out_ready        in   1               consumer accepts out_data
//  S_oe_ram         out  N_CH            slave read enable per channel
//  S_we_ram         out  N_CH            slave write enable per channel
//  S_addr_ram       out  N_CH*ADDR_W     slave address, channel 0 in LSBs
//  S_Wdata_ram      out  N_CH*DATA_W     slave write data
//  S_data_ram_size  out  N_CH*SIZE_W     access size in bits
//  start_port       out  1               1-cycle start pulse to main
//  done_port        in   1               main completion
//  Sout_Rdata_ram   in   N_CH*DATA_W     slave read data
//  Sout_DataRdy     in   N_CH            slave access acknowledge
//  busy / finished  out  1 / 1           pass in progress / pass complete (sticky until next go)
//  sorted_ok        out  1               valid when finished: all elements nondecreasing
//  timed_out        out  1               sticky, set when RUN exceeds TIMEOUT
//  cycles           out  32              RUN cycles: start_port pulse to done_port, inclusive
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, every output 0, counters 0, sorted_ok 0.
//  FSM: IDLE -go-> LOAD -> START -> RUN -> READ -> FIN -go-> LOAD.
//  LOAD: in_ready=1 only while no access is outstanding. On in_valid&in_ready, drive we[0]=1, addr=BASE_ADDR+idx,
//   Wdata[7:0]=in_data, size[3:0]=8 on that cycle and hold them until Sout_DataRdy[0]; then idx++.
//   After idx==N_BYTES, go to START.
//  START: start_port=1 for exactly one cycle; cycles<=1; go to RUN.
//  RUN: cycles++ (saturates at 2^32-1) until done_port; done in the same cycle as the START pulse is legal (cycles=1).
//   If cycles reaches TIMEOUT: timed_out=1, sorted_ok=0, go directly to FIN.
//  READ: issue oe[0]=1 per byte and hold it until DataRdy; latch Rdata[7:0] into an output register.
//   out_valid=1 until out_ready; the next read issues only after the handshake. Backpressure is unbounded.
//  Sorted check: shift bytes into a little-endian ELEM_BYTES word. At each word boundary, compare signed
//   against the previous word (from the 2nd element on); any decrease clears an internal ok flag.
//  FIN: finished=1, busy=0, sorted_ok=ok flag. A new go clears finished/timed_out/cycles and restarts LOAD.
//  busy=1 in LOAD..READ. go while busy is ignored. DataRdy without an outstanding access is ignored.
//  Address width: BASE_ADDR+idx truncated to ADDR_W bits (wrap allowed, no error).
//  S_* channels >0 are always 0. A reset mid-pass aborts silently with no partial flags.
// STRUCTURE
//  Shared package: FSM state enum, ACCESS_BITS=DATA_W constant, slave-field slicing helpers per channel.
//  One sub-module: msl_sort_checker (byte in + last flag -> sorted_ok), reused by the CPU-side model.
// TESTING
//  Load 8 ints {5,-1,7,3,0,9,2,2}, main model sorts -> 32 out bytes = {-1,0,2,2,3,5,7,9} LE, sorted_ok=1.
//  Model skips sorting -> readback unchanged, sorted_ok=0, finished=1.
//  DataRdy delayed 0..5 random cycles, in_valid/out_ready toggled randomly -> same bytes, no dup/loss.
//  done_port held low -> timed_out=1 after TIMEOUT (set 100 in bench), finished=1, no READ accesses.
//  Assert reset mid-LOAD at byte 13 -> all outputs 0 immediately; later go -> full clean pass.
//  done_port high on cycle right after start pulse -> cycles=1; go during READ ignored.

Source files
------------

// File: rtl/mergesort_slave_loader_pkg.sv
// Shared definitions for the mergesort slave loader: FSM encoding, access width
// and per-channel field offsets on the flattened slave buses.
package mergesort_slave_loader_pkg;

  localparam int ACCESS_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  // LSB position of channel ch inside a bus of per-channel fields of the given width
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/msl_sort_checker.sv
// Assembles little-endian elements from a byte stream and clears ok on any
// signed decrease between consecutive elements.
module msl_sort_checker #(
  parameter int DATA_W     = 8,
  parameter int ELEM_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              ok
);

  localparam int WORD_W = DATA_W * ELEM_BYTES;
  localparam int CNT_W  = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] prev_q;
  logic              have_prev;
  logic [WORD_W-1:0] word;
  logic              word_done;

  // New bytes enter at the top so byte 0 ends up in the LSBs once the word fills
  always_comb begin
    word      = (shift_q >> DATA_W) | (WORD_W'(byte_data) << (WORD_W - DATA_W));
    word_done = (cnt == CNT_W'(ELEM_BYTES - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      shift_q   <= '0;
      prev_q    <= '0;
      have_prev <= 1'b0;
      ok        <= 1'b1;
    end else if (clear) begin
      cnt       <= '0;
      shift_q   <= '0;
      prev_q    <= '0;
      have_prev <= 1'b0;
      ok        <= 1'b1;
    end else if (byte_valid) begin
      shift_q <= word;
      if (word_done) begin
        cnt       <= '0;
        prev_q    <= word;
        have_prev <= 1'b1;
        if (have_prev && ($signed(word) < $signed(prev_q))) ok <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mergesort_slave_loader.sv
// Preloads main's slave RAM from a byte stream, starts and times the sort run,
// then streams the array back out while checking that it is sorted.
//
// state    | meaning
// IDLE     | waiting for go
// LOAD     | writing input bytes into the slave RAM
// START    | one-cycle start pulse to main
// RUN      | counting cycles until done_port or timeout
// READ     | reading bytes back and presenting them on out_*
// FIN      | pass complete, results held until next go
module mergesort_slave_loader
  import mergesort_slave_loader_pkg::*;
#(
  parameter int          N_CH       = 2,
  parameter int          ADDR_W     = 7,
  parameter int          DATA_W     = ACCESS_BITS,
  parameter int          SIZE_W     = 4,
  parameter int          N_BYTES    = 32,
  parameter int          ELEM_BYTES = 4,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned TIMEOUT    = 200000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [N_CH-1:0]          S_oe_ram,
  output logic [N_CH-1:0]          S_we_ram,
  output logic [N_CH*ADDR_W-1:0]   S_addr_ram,
  output logic [N_CH*DATA_W-1:0]   S_Wdata_ram,
  output logic [N_CH*SIZE_W-1:0]   S_data_ram_size,
  output logic                     start_port,
  input  logic                     done_port,
  input  logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [N_CH-1:0]          Sout_DataRdy,
  output logic                     busy,
  output logic                     finished,
  output logic                     sorted_ok,
  output logic                     timed_out,
  output logic [31:0]              cycles
);

  localparam int IDX_W = $clog2(N_BYTES + 1);

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              pend;
  logic [DATA_W-1:0] wdata_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              we0;
  logic              oe0;
  logic              rdy0;
  logic [DATA_W-1:0] rdata0;
  logic [ADDR_W-1:0] addr0;
  logic              last_byte;
  logic              go_ok;
  logic              chk_ok;
  logic              unused_bits;

  assign rdy0        = Sout_DataRdy[0];
  assign rdata0      = Sout_Rdata_ram[ch_lsb(0, DATA_W) +: DATA_W];
  assign unused_bits = ^{Sout_Rdata_ram, Sout_DataRdy};
  assign last_byte   = (idx == IDX_W'(N_BYTES - 1));
  assign go_ok       = go && ((state == ST_IDLE) || (state == ST_FIN));
  assign addr0       = ADDR_W'(BASE_ADDR + 32'(idx));

  // A write is presented in the accept cycle itself, so a zero-latency slave completes it there
  always_comb begin
    in_ready   = (state == ST_LOAD) && !pend;
    we0        = (state == ST_LOAD) && (pend || in_valid);
    oe0        = (state == ST_READ) && !out_valid_q;
    start_port = (state == ST_START);
    busy       = (state == ST_LOAD) || (state == ST_START) ||
                 (state == ST_RUN)  || (state == ST_READ);
    finished   = (state == ST_FIN);
    out_valid  = out_valid_q;
    out_data   = out_data_q;
  end

  always_comb begin
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    S_oe_ram[0]     = oe0;
    S_we_ram[0]     = we0;
    if (we0 || oe0) begin
      S_addr_ram[ch_lsb(0, ADDR_W) +: ADDR_W]      = addr0;
      S_data_ram_size[ch_lsb(0, SIZE_W) +: SIZE_W] = SIZE_W'(DATA_W);
    end
    if (we0) S_Wdata_ram[ch_lsb(0, DATA_W) +: DATA_W] = pend ? wdata_q : in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      pend        <= 1'b0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sorted_ok   <= 1'b0;
      timed_out   <= 1'b0;
      cycles      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          if (go_ok) begin
            state       <= ST_LOAD;
            idx         <= '0;
            pend        <= 1'b0;
            out_valid_q <= 1'b0;
            sorted_ok   <= 1'b0;
            timed_out   <= 1'b0;
            cycles      <= '0;
          end
        end
        ST_LOAD: begin
          if (we0 && rdy0) begin
            pend <= 1'b0;
            if (last_byte) begin
              idx   <= '0;
              state <= ST_START;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (in_valid && in_ready) begin
            pend    <= 1'b1;
            wdata_q <= in_data;
          end
        end
        ST_START: begin
          cycles <= 32'd1;
          state  <= done_port ? ST_READ : ST_RUN;
        end
        ST_RUN: begin
          if (done_port) begin
            state <= ST_READ;
          end else if (cycles >= TIMEOUT) begin
            timed_out <= 1'b1;
            sorted_ok <= 1'b0;
            state     <= ST_FIN;
          end else if (cycles != 32'hFFFF_FFFF) begin
            cycles <= cycles + 32'd1;
          end
        end
        ST_READ: begin
          if (oe0 && rdy0) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rdata0;
          end
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (last_byte) begin
              idx       <= '0;
              sorted_ok <= chk_ok;
              state     <= ST_FIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  msl_sort_checker #(
    .DATA_W     (DATA_W),
    .ELEM_BYTES (ELEM_BYTES)
  ) u_checker (
    .clock      (clock),
    .reset      (reset),
    .clear      (go_ok),
    .byte_valid (oe0 && rdy0),
    .byte_data  (rdata0),
    .ok         (chk_ok)
  );

endmodule

// File: tb/tb_mergesort_slave_loader.sv
// Scoreboard bench: a RAM/main model sorts (or not) the loaded ints, expected
// readback bytes are queued per pass and popped by an independent monitor.
module tb_mergesort_slave_loader;

  localparam int TIMEOUT_TB = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [1:0]  S_oe_ram;
  logic [1:0]  S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        start_port;
  logic        done_port = 1'b0;
  logic [15:0] Sout_Rdata_ram = 16'd0;
  logic [1:0]  Sout_DataRdy = 2'b00;
  logic        busy;
  logic        finished;
  logic        sorted_ok;
  logic        timed_out;
  logic [31:0] cycles;

  logic [7:0] mem [128];
  logic [7:0] exp_q [$];
  int main_mode = 0;   // 0 sorts, 1 leaves data untouched, 2 never signals done
  int done_delay = 1;
  int rd_acc = 0;
  int starts = 0;
  int total = 0;
  int bad = 0;

  mergesort_slave_loader #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clock(clock), .reset(reset), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .start_port(start_port), .done_port(done_port),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .busy(busy), .finished(finished), .sorted_ok(sorted_ok),
    .timed_out(timed_out), .cycles(cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got bound expired expected event", name);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, 64'({in_ready, out_valid, out_data, S_oe_ram, S_we_ram, S_addr_ram,
           S_Wdata_ram, S_data_ram_size, start_port, busy, finished, sorted_ok, timed_out}), 64'd0);
    check({tag, "_cycles"}, 64'(cycles), 64'd0);
  endtask

  // Slave RAM: acknowledges each access after 0..5 cycles, plus stray acks while idle
  initial begin : slave
    int wl;
    logic [6:0] a;
    wl = -1;
    forever begin
      @(negedge clock);
      Sout_DataRdy = 2'b00;
      Sout_Rdata_ram = 16'($urandom());
      if (!reset) begin
        wl = -1;
      end else if (S_we_ram[0] || S_oe_ram[0]) begin
        if (wl < 0) wl = int'($urandom_range(0, 5));
        if (wl == 0) begin
          a = S_addr_ram[6:0];
          if (S_we_ram[0]) mem[a] = S_Wdata_ram[7:0];
          else begin
            Sout_Rdata_ram[7:0] = mem[a];
            rd_acc++;
          end
          Sout_DataRdy[0] = 1'b1;
          wl = -1;
        end else begin
          wl--;
        end
      end else begin
        Sout_DataRdy[0] = ($urandom_range(0, 7) == 0);
        Sout_DataRdy[1] = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Model of main: on start, sort the ints held in RAM, then raise done after done_delay cycles
  initial begin : main_model
    int w[$];
    forever begin
      @(negedge clock);
      if (reset && start_port) begin
        starts++;
        if (main_mode == 0) begin
          w.delete();
          for (int e = 0; e < 8; e++)
            w.push_back(int'({mem[4*e+3], mem[4*e+2], mem[4*e+1], mem[4*e]}));
          w.sort();
          for (int e = 0; e < 8; e++)
            for (int k = 0; k < 4; k++) mem[4*e+k] = 8'(w[e] >> (8*k));
        end
        if (main_mode != 2) begin
          repeat (done_delay) @(negedge clock);
          done_port = 1'b1;
          @(negedge clock);
          done_port = 1'b0;
        end
      end
    end
  end

  // Consumer with random backpressure; every accepted byte is matched against the scoreboard
  initial begin : monitor
    forever begin
      @(posedge clock);
      #1 out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clock);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %0h expected none", out_data);
        end else begin
          check("rd_byte", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic to_bytes(input int v[8], output logic [7:0] b[32]);
    for (int e = 0; e < 8; e++)
      for (int k = 0; k < 4; k++) b[4*e+k] = 8'(v[e] >> (8*k));
  endtask

  task automatic pulse_go();
    @(posedge clock);
    #1 go = 1'b1;
    @(posedge clock);
    #1 go = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b[32], input int stop_at);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < stop_at && guard < 3000) begin
      @(posedge clock);
      #1 in_valid = ($urandom_range(0, 3) != 0);
      in_data = in_valid ? b[i] : 8'($urandom());
      @(negedge clock);
      if (in_valid && in_ready) i++;
      guard++;
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    if (i < stop_at) fail("feed_bytes");
  endtask

  task automatic run_pass(input int v[8], input int mode, input int dd, input bit go_in_read);
    logic [7:0] b[32];
    int q[$];
    bit exp_ok;
    int guard;
    int exp_cyc;
    main_mode = mode;
    done_delay = dd;
    rd_acc = 0;
    starts = 0;
    to_bytes(v, b);
    q.delete();
    foreach (v[e]) q.push_back(v[e]);
    if (mode == 0) q.sort();
    exp_ok = (mode != 2);
    for (int e = 1; e < 8; e++) if (q[e] < q[e-1]) exp_ok = 1'b0;
    if (mode != 2)
      for (int e = 0; e < 8; e++)
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(q[e] >> (8*k)));
    exp_cyc = (mode == 2) ? TIMEOUT_TB : ((dd == 0) ? 1 : dd);

    pulse_go();
    check("busy_after_go", 64'(busy), 64'd1);
    feed(b, 32);
    if (go_in_read) begin
      guard = 0;
      while (!out_valid && guard < 2000) begin
        @(negedge clock);
        guard++;
      end
      if (!out_valid) fail("wait_read");
      pulse_go();
      check("go_in_read_busy", 64'({busy, finished}), 64'b10);
    end
    guard = 0;
    while (!finished && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (!finished) fail("wait_finished");
    @(negedge clock);
    check("fin_busy", 64'({finished, busy}), 64'b10);
    check("sorted_ok", 64'(sorted_ok), 64'(exp_ok));
    check("timed_out", 64'(timed_out), 64'(mode == 2));
    check("cycles", 64'(cycles), 64'(exp_cyc));
    check("starts", 64'(starts), 64'd1);
    check("read_accesses", 64'(rd_acc), (mode == 2) ? 64'd0 : 64'd32);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int v[8];
    logic [7:0] b[32];
    #2 reset = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    v = '{5, -1, 7, 3, 0, 9, 2, 2};
    run_pass(v, 0, 3, 1'b0);
    run_pass(v, 1, 2, 1'b0);

    v = '{2147483647, int'(32'h8000_0000), 0, -1, 1, 5, 5, -5};
    run_pass(v, 0, 4, 1'b0);

    for (int t = 0; t < 2; t++) begin
      foreach (v[e]) v[e] = int'($urandom());
      run_pass(v, 0, int'($urandom_range(2, 9)), 1'b0);
    end
    foreach (v[e]) v[e] = int'($urandom_range(0, 20)) - 10;
    run_pass(v, 1, 4, 1'b0);

    v = '{-7, -7, 0, 1, 1, 2, 50, 50};
    run_pass(v, 1, 1, 1'b1);
    run_pass(v, 0, 0, 1'b0);
    run_pass(v, 2, 0, 1'b0);

    foreach (v[e]) v[e] = int'($urandom());
    to_bytes(v, b);
    main_mode = 0;
    done_delay = 2;
    pulse_go();
    feed(b, 13);
    reset = 1'b0;
    #1 check_zero("mid_load_reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    run_pass(v, 0, 5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
